// File: rtl/pll_speed_reconfig.sv
// Reprograms the PLL fractional divider (mode, fraction, start) over Avalon-MM
// whenever the filtered speed request differs from the last committed setting.
module pll_speed_reconfig #(
    parameter logic [31:0] FRAC_NATIVE   = 32'd3639383488,
    parameter logic [31:0] FRAC_UNDER    = 32'd3262113561,
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES    = 3,
    parameter int unsigned LOCK_HOLDOFF  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535
) (
    input  logic        clk_50m,
    input  logic        reset,
    input  logic        underclock,
    input  logic        mgmt_waitrequest,
    output logic        mgmt_write,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    input  logic        pll_locked,
    output logic        busy,
    output logic        applied,
    output logic        lock_err
);

    localparam logic [3:0]  STABLE_C     = 4'(STABLE_CYCLES);
    localparam logic [3:0]  GAP_LAST     = 4'(GAP_CYCLES - 1);
    localparam logic [15:0] HOLDOFF_C    = 16'(LOCK_HOLDOFF);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);

    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_START = 6'd2;
    localparam logic [5:0] ADDR_FRAC  = 6'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_MODE,
        S_GAP1,
        S_WR_FRAC,
        S_GAP2,
        S_WR_START,
        S_LOCK_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic        target_q, target_d;
    logic        wr_q, wr_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] lock_cnt_q, lock_cnt_d;
    logic        applied_q, applied_d;
    logic        lock_err_q, lock_err_d;
    logic        busy_q, busy_d;

    logic        u_meta_q, u_sync_q, u_prev_q;
    logic [3:0]  stab_cnt_q, stab_cnt_d;
    logic        u_st_q, u_st_d;

    logic        lock_meta_q, lock_sync_q;
    logic        lock_arm;
    logic        accept;
    logic [31:0] frac_word;

    // ---------------- request filter ----------------
    always_ff @(posedge clk_50m or negedge reset) begin
        if (!reset) begin
            u_meta_q   <= 1'b0;
            u_sync_q   <= 1'b0;
            u_prev_q   <= 1'b0;
            stab_cnt_q <= 4'd0;
            u_st_q     <= 1'b0;
        end else begin
            u_meta_q   <= underclock;
            u_sync_q   <= u_meta_q;
            u_prev_q   <= u_sync_q;
            stab_cnt_q <= stab_cnt_d;
            u_st_q     <= u_st_d;
        end
    end

    // stab_cnt counts consecutive equal synchronized samples, the new one included
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        u_st_d     = u_st_q;
        if (u_sync_q != u_prev_q) begin
            stab_cnt_d = 4'd1;
        end else if (stab_cnt_q < STABLE_C) begin
            stab_cnt_d = stab_cnt_q + 4'd1;
        end
        if (stab_cnt_d == STABLE_C) begin
            u_st_d = u_sync_q;
        end
    end

    // ---------------- lock synchronizer ----------------
    // Held clear until the holdoff expires so a stale pre-reconfig lock cannot
    // complete the wait; a genuine lock then needs two more cycles to appear.
    assign lock_arm = (state_q == S_LOCK_WAIT) && (lock_cnt_q >= HOLDOFF_C);

    always_ff @(posedge clk_50m or negedge reset) begin
        if (!reset) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else if (!lock_arm) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    // ---------------- sequencer ----------------
    assign accept    = wr_q && !mgmt_waitrequest;
    assign frac_word = target_q ? FRAC_UNDER : FRAC_NATIVE;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        gap_cnt_d  = gap_cnt_q;
        lock_cnt_d = lock_cnt_q;
        applied_d  = applied_q;
        lock_err_d = lock_err_q;

        case (state_q)
            S_IDLE: begin
                if (u_st_q != applied_q) begin
                    target_d = u_st_q;
                    state_d  = S_WR_MODE;
                    wr_d     = 1'b1;
                    addr_d   = ADDR_MODE;
                    data_d   = 32'd0;
                end
            end
            S_WR_MODE: begin
                if (accept) begin
                    wr_d      = 1'b0;
                    gap_cnt_d = 4'd0;
                    state_d   = S_GAP1;
                end
            end
            S_GAP1: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_WR_FRAC;
                    wr_d    = 1'b1;
                    addr_d  = ADDR_FRAC;
                    data_d  = frac_word;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            S_WR_FRAC: begin
                if (accept) begin
                    wr_d      = 1'b0;
                    gap_cnt_d = 4'd0;
                    state_d   = S_GAP2;
                end
            end
            S_GAP2: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_WR_START;
                    wr_d    = 1'b1;
                    addr_d  = ADDR_START;
                    data_d  = 32'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            S_WR_START: begin
                if (accept) begin
                    wr_d       = 1'b0;
                    lock_cnt_d = 16'd0;
                    state_d    = S_LOCK_WAIT;
                end
            end
            S_LOCK_WAIT: begin
                if (lock_arm && lock_sync_q) begin
                    applied_d  = target_q;
                    lock_err_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (lock_cnt_q == TIMEOUT_LAST) begin
                    applied_d  = target_q;
                    lock_err_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                wr_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_50m or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            target_q   <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 6'd0;
            data_q     <= 32'd0;
            gap_cnt_q  <= 4'd0;
            lock_cnt_q <= 16'd0;
            applied_q  <= 1'b0;
            lock_err_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            gap_cnt_q  <= gap_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            applied_q  <= applied_d;
            lock_err_q <= lock_err_d;
            busy_q     <= busy_d;
        end
    end

    assign mgmt_write     = wr_q;
    assign mgmt_address   = addr_q;
    assign mgmt_writedata = data_q;
    assign busy           = busy_q;
    assign applied        = applied_q;
    assign lock_err       = lock_err_q;

endmodule
